// File: rtl/cam_cfg_pkg.sv
// Shared state encoding and table tags for the camera
// configuration sequencer.
package cam_cfg_pkg;

  typedef enum logic [3:0] {
    PWR_RST    = 4'd0,
    PWR_SETTLE = 4'd1,
    FETCH      = 4'd2,
    DECODE     = 4'd3,
    ISSUE      = 4'd4,
    WAIT_DONE  = 4'd5,
    DELAY      = 4'd6,
    DONE       = 4'd7,
    ERROR      = 4'd8
  } cfg_state_t;

  localparam logic [15:0] CFG_END       = 16'hFFFF;
  localparam logic [7:0]  CFG_DELAY_TAG = 8'hF0;

endpackage

// File: rtl/cam_config_sequencer_ms_timer.sv
// ms_timer: prescaler plus 8-bit millisecond down-counter.
// Ports: start/ms load a wait, expired is high on its last cycle.
module ms_timer #(
  parameter int CYCLES_PER_MS = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] ms,
  output logic       expired
);

  localparam int PW =
    (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST =
    PW'(CYCLES_PER_MS - 1);

  logic [PW-1:0] presc;
  logic [7:0]    ms_cnt;
  logic          running;
  logic          tick;

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc   <= '0;
      ms_cnt  <= '0;
      running <= 1'b0;
    end else if (start) begin
      presc   <= '0;
      ms_cnt  <= ms;
      running <= (ms != 8'd0);
    end else if (running) begin
      if (tick) begin
        presc   <= '0;
        ms_cnt  <= ms_cnt - 8'd1;
        running <= (ms_cnt != 8'd1);
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Expired on the final cycle so the owner leaves the
  // timed state after exactly ms*CYCLES_PER_MS cycles;
  // an idle timer (zero-length wait) reads as expired.
  assign expired = !running || (tick && ms_cnt == 8'd1);

endmodule

// File: rtl/cam_config_sequencer.sv
// cam_config_sequencer: power-up sequencing and ROM-driven
// SCCB register programming. Ports: rom_*, cmd_*, cam_*, status.
module cam_config_sequencer
  import cam_cfg_pkg::*;
#(
  parameter int CYCLES_PER_MS = 25000,
  parameter int PWRUP_MS      = 10,
  parameter int MAX_RETRY     = 3,
  parameter int ADDR_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              resend,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [7:0]        cmd_reg,
  output logic [7:0]        cmd_val,
  input  logic              cmd_done,
  input  logic              cmd_nack,
  output logic              cam_reset_n,
  output logic              cam_pwdn,
  output logic              config_finished,
  output logic              config_error,
  output logic              busy
);

  localparam int RW =
    (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [7:0]    PWR_MS    = 8'(PWRUP_MS);

  cfg_state_t     state, state_d;
  logic [RW-1:0]  retry;
  logic           resend_q;
  logic           resend_rise;
  logic           boot;
  logic           tmr_start;
  logic [7:0]     tmr_ms;
  logic           tmr_exp;
  logic           tmr_done;
  logic           advance;
  logic           addr_inc;
  logic           addr_clr;
  logic           retry_inc;
  logic           retry_clr;
  logic           cmd_load;
  logic           last_addr;

  ms_timer #(
    .CYCLES_PER_MS(CYCLES_PER_MS)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (tmr_start),
    .ms     (tmr_ms),
    .expired(tmr_exp)
  );

  assign resend_rise = resend && !resend_q;
  assign last_addr   = (rom_addr == '1);
  // The first cycle after reset arms the power-up wait, so
  // the idle timer must not be read as already expired.
  assign tmr_done    = tmr_exp && !boot;

  always_comb begin
    state_d   = state;
    tmr_start = boot;
    tmr_ms    = PWR_MS;
    advance   = 1'b0;
    addr_inc  = 1'b0;
    addr_clr  = 1'b0;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    cmd_load  = 1'b0;
    if (resend_rise) begin
      state_d   = PWR_RST;
      tmr_start = 1'b1;
      retry_clr = 1'b1;
    end else begin
      unique case (state)
        PWR_RST: begin
          if (tmr_done) begin
            state_d   = PWR_SETTLE;
            tmr_start = 1'b1;
          end
        end
        PWR_SETTLE: begin
          if (tmr_done) begin
            state_d  = FETCH;
            addr_clr = 1'b1;
          end
        end
        FETCH: state_d = DECODE;
        DECODE: begin
          if (rom_data == CFG_END) begin
            state_d = DONE;
          end else if (rom_data[15:8] == CFG_DELAY_TAG) begin
            state_d   = DELAY;
            tmr_start = 1'b1;
            tmr_ms    = rom_data[7:0];
          end else begin
            state_d  = ISSUE;
            cmd_load = 1'b1;
          end
        end
        ISSUE: begin
          if (cmd_ready) state_d = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (cmd_done) begin
            if (!cmd_nack) begin
              retry_clr = 1'b1;
              advance   = 1'b1;
            end else if (retry < RETRY_MAX) begin
              retry_inc = 1'b1;
              state_d   = ISSUE;
            end else begin
              state_d = ERROR;
            end
          end
        end
        DELAY: begin
          if (tmr_done) advance = 1'b1;
        end
        default: ;
      endcase
      // The last ROM slot ends the table even without a
      // terminator; the address never wraps.
      if (advance) begin
        if (last_addr) begin
          state_d = DONE;
        end else begin
          state_d  = FETCH;
          addr_inc = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= PWR_RST;
      rom_addr <= '0;
      retry    <= '0;
      cmd_reg  <= '0;
      cmd_val  <= '0;
      resend_q <= 1'b0;
      boot     <= 1'b1;
    end else begin
      state    <= state_d;
      resend_q <= resend;
      boot     <= 1'b0;
      if (addr_clr)      rom_addr <= '0;
      else if (addr_inc) rom_addr <= rom_addr + 1'b1;
      if (retry_clr)      retry <= '0;
      else if (retry_inc) retry <= retry + 1'b1;
      if (cmd_load) begin
        cmd_reg <= rom_data[15:8];
        cmd_val <= rom_data[7:0];
      end
    end
  end

  assign cmd_valid       = (state == ISSUE);
  assign cam_reset_n     = (state != PWR_RST);
  assign cam_pwdn        = 1'b0;
  assign config_finished = (state == DONE);
  assign config_error    = (state == ERROR);
  assign busy            = (state != DONE) &&
                           (state != ERROR);

endmodule

// File: tb/tb_cam_config_sequencer.sv
// Directed bench for cam_config_sequencer with a ROM model
// and an SCCB responder that can NACK on request.
module tb_cam_config_sequencer;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          resend = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic [7:0]    cmd_reg;
  logic [7:0]    cmd_val;
  logic          cmd_done = 1'b0;
  logic          cmd_nack = 1'b0;
  logic          cam_reset_n;
  logic          cam_pwdn;
  logic          config_finished;
  logic          config_error;
  logic          busy;

  logic [15:0] rom [16];
  logic [7:0]  iss_reg [64];
  logic [7:0]  iss_val [64];
  int          iss_n = 0;
  int          wait_cnt = 0;
  int          nack_base = 0;
  int          nack_first = 0;
  bit          nack_all = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          lat_base = 22;

  cam_config_sequencer #(
    .CYCLES_PER_MS(10),
    .PWRUP_MS     (2),
    .MAX_RETRY    (3),
    .ADDR_W       (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .resend         (resend),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_reg        (cmd_reg),
    .cmd_val        (cmd_val),
    .cmd_done       (cmd_done),
    .cmd_nack       (cmd_nack),
    .cam_reset_n    (cam_reset_n),
    .cam_pwdn       (cam_pwdn),
    .config_finished(config_finished),
    .config_error   (config_error),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(posedge clk) begin
    cmd_done <= 1'b0;
    cmd_nack <= 1'b0;
    if (cmd_valid && cmd_ready) begin
      if (iss_n < 64) begin
        iss_reg[iss_n] <= cmd_reg;
        iss_val[iss_n] <= cmd_val;
      end
      iss_n    <= iss_n + 1;
      wait_cnt <= 3;
    end else if (wait_cnt != 0) begin
      wait_cnt <= wait_cnt - 1;
      if (wait_cnt == 1) begin
        cmd_done <= 1'b1;
        cmd_nack <= nack_all ||
                    ((iss_n - 1 - nack_base) < nack_first);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  task automatic load_rom(input logic [15:0] a,
                          input logic [15:0] b,
                          input logic [15:0] c);
    for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
    rom[0] = a;
    rom[1] = b;
    rom[2] = c;
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    resend = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_issues(input int target,
                             input int budget,
                             output bit ok);
    int n;
    n = 0;
    while (iss_n < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (iss_n >= target);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    ok = !busy;
  endtask

  task automatic measure(output int t_rise,
                         output int t_val);
    t_rise = -1;
    t_val  = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (cam_reset_n && t_rise < 0) t_rise = n;
      if (cmd_valid) begin
        t_val = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0]  flags;
    logic [15+AW:0] vals;
    load_rom(16'h1280, 16'h1204, 16'hFFFF);
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    flags = {cam_reset_n, cam_pwdn, cmd_valid,
             config_finished, config_error, busy};
    checks++;
    if (flags !== 6'b000001) begin
      errors++;
      $display("FAIL reset_flags got=%b want=000001", flags);
    end
    vals = {cmd_reg, cmd_val, rom_addr};
    checks++;
    if (vals !== '0) begin
      errors++;
      $display("FAIL reset_regs got=%h want=0", vals);
    end
  endtask

  task automatic test_basic();
    int t_rise, t_val, base;
    bit ok;
    load_rom(16'h1280, 16'h1204, 16'hFFFF);
    cmd_ready = 1'b1;
    base = iss_n;
    do_reset();
    measure(t_rise, t_val);
    checks++;
    if (t_rise < 20 || t_rise > 21) begin
      errors++;
      $display("FAIL pwr_rst_len got=%0d want=20..21",
               t_rise);
    end
    checks++;
    if (t_val - t_rise != 22) begin
      errors++;
      $display("FAIL settle_latency got=%0d want=22",
               t_val - t_rise);
    end
    wait_issues(base + 2, 300, ok);
    checks++;
    if (!ok || iss_reg[base] !== 8'h12 ||
        iss_val[base] !== 8'h80) begin
      errors++;
      $display("FAIL basic_first got=%h/%h want=12/80",
               iss_reg[base], iss_val[base]);
    end
    checks++;
    if (!ok || iss_reg[base+1] !== 8'h12 ||
        iss_val[base+1] !== 8'h04) begin
      errors++;
      $display("FAIL basic_second got=%h/%h want=12/04",
               iss_reg[base+1], iss_val[base+1]);
    end
    wait_idle(200, ok);
    checks++;
    if (!ok || {config_finished, config_error, busy}
               !== 3'b100) begin
      errors++;
      $display("FAIL basic_done got=%b%b%b want=100",
               config_finished, config_error, busy);
    end
  endtask

  task automatic test_delay();
    int t_rise, t_val, base, gap;
    bit ok;
    load_rom(16'hF005, 16'h1100, 16'hFFFF);
    cmd_ready = 1'b1;
    base = iss_n;
    do_reset();
    measure(t_rise, t_val);
    gap = (t_val - t_rise) - lat_base;
    checks++;
    if (t_val < 0 || gap < 48 || gap > 52) begin
      errors++;
      $display("FAIL delay_gap got=%0d want=48..52", gap);
    end
    wait_issues(base + 1, 100, ok);
    checks++;
    if (!ok || iss_reg[base] !== 8'h11 ||
        iss_val[base] !== 8'h00) begin
      errors++;
      $display("FAIL delay_cmd got=%h/%h want=11/00",
               iss_reg[base], iss_val[base]);
    end
    wait_idle(200, ok);
  endtask

  task automatic test_retry();
    int base, bad;
    bit ok;
    load_rom(16'h1234, 16'h5678, 16'hFFFF);
    cmd_ready  = 1'b1;
    base       = iss_n;
    nack_base  = iss_n;
    nack_first = 2;
    do_reset();
    wait_idle(800, ok);
    checks++;
    if (iss_n - base !== 4) begin
      errors++;
      $display("FAIL retry_count got=%0d want=4",
               iss_n - base);
    end
    bad = 0;
    for (int i = 0; i < 3; i++)
      if (iss_reg[base+i] !== 8'h12 ||
          iss_val[base+i] !== 8'h34) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL retry_same got=%0d bad want=0", bad);
    end
    checks++;
    if (iss_reg[base+3] !== 8'h56 ||
        iss_val[base+3] !== 8'h78) begin
      errors++;
      $display("FAIL retry_next got=%h/%h want=56/78",
               iss_reg[base+3], iss_val[base+3]);
    end
    checks++;
    if (!ok || {config_finished, config_error} !== 2'b10)
    begin
      errors++;
      $display("FAIL retry_status got=%b%b want=10",
               config_finished, config_error);
    end
    nack_first = 0;
  endtask

  task automatic test_error();
    int base;
    bit ok;
    load_rom(16'h1234, 16'hFFFF, 16'hFFFF);
    cmd_ready = 1'b1;
    base      = iss_n;
    nack_all  = 1'b1;
    do_reset();
    wait_idle(800, ok);
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (iss_n - base !== 4) begin
      errors++;
      $display("FAIL error_count got=%0d want=4",
               iss_n - base);
    end
    checks++;
    if (!ok || {config_finished, config_error, busy}
               !== 3'b010) begin
      errors++;
      $display("FAIL error_status got=%b%b%b want=010",
               config_finished, config_error, busy);
    end
    nack_all = 1'b0;
  endtask

  task automatic test_stall_resend();
    int n, bad, base;
    bit ok;
    load_rom(16'h2A55, 16'hFFFF, 16'hFFFF);
    cmd_ready = 1'b0;
    do_reset();
    n = 0;
    while (!cmd_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    bad = cmd_valid ? 0 : 1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (cmd_valid !== 1'b1 || cmd_reg !== 8'h2A ||
          cmd_val !== 8'h55) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_stable got=%0d bad want=0", bad);
    end
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL handshake_drop got=%b want=0",
               cmd_valid);
    end
    resend = 1'b1;
    @(posedge clk); #1;
    resend = 1'b0;
    checks++;
    if ({cmd_valid, cam_reset_n, busy} !== 3'b001) begin
      errors++;
      $display("FAIL resend_abort got=%b%b%b want=001",
               cmd_valid, cam_reset_n, busy);
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (cam_reset_n !== 1'b0) begin
      errors++;
      $display("FAIL late_done got=%b want=0", cam_reset_n);
    end
    base = iss_n;
    wait_issues(base + 1, 300, ok);
    checks++;
    if (!ok || iss_reg[base] !== 8'h2A ||
        iss_val[base] !== 8'h55) begin
      errors++;
      $display("FAIL restart_cmd got=%h/%h want=2A/55",
               iss_reg[base], iss_val[base]);
    end
    wait_idle(200, ok);
    resend = 1'b1;
    @(posedge clk); #1;
    resend = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (!ok || {config_finished, busy, cam_reset_n}
               !== 3'b010) begin
      errors++;
      $display("FAIL resend_from_done got=%b%b%b want=010",
               config_finished, busy, cam_reset_n);
    end
  endtask

  task automatic test_no_terminator();
    int base;
    bit ok;
    for (int i = 0; i < 16; i++)
      rom[i] = 16'h3300 | 16'(i);
    cmd_ready = 1'b1;
    base      = iss_n;
    do_reset();
    wait_idle(2000, ok);
    checks++;
    if (iss_n - base !== 16) begin
      errors++;
      $display("FAIL noterm_count got=%0d want=16",
               iss_n - base);
    end
    checks++;
    if (iss_reg[base+15] !== 8'h33 ||
        iss_val[base+15] !== 8'h0F) begin
      errors++;
      $display("FAIL noterm_last got=%h/%h want=33/0F",
               iss_reg[base+15], iss_val[base+15]);
    end
    checks++;
    if (!ok || {config_finished, rom_addr} !==
               {1'b1, 4'hF}) begin
      errors++;
      $display("FAIL noterm_done got=%b/%h want=1/F",
               config_finished, rom_addr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay();
    test_retry();
    test_error();
    test_stall_resend();
    test_no_terminator();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
